// File: rtl/fm_buffer_read_ctrl_pkg.sv
// Shared types and default sizing for the feature-map read-side controller.
// Width constants below describe the default 8-kernel, 1024-word configuration.
package fm_buffer_read_ctrl_pkg;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_KERNELS_DEF = 8;
    localparam int FM_DEPTH_DEF    = 1024;
    localparam int RAM_LAT_DEF     = 2;

    localparam int FM_ADDR_W = clog2_w(FM_DEPTH_DEF);
    localparam int KSEL_W    = clog2_w(NUM_KERNELS_DEF);
    localparam int WADDR_W   = clog2_w(NUM_KERNELS_DEF * FM_DEPTH_DEF);
    localparam int PIXEL_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_RELEASE
    } rd_state_e;

endpackage

// File: rtl/fm_rd_valid_pipe.sv
// Delay line carrying the read-issue valid and last flags alongside the RAM
// read latency plus the output pixel register; DEPTH must be at least 2.
module fm_rd_valid_pipe
    import fm_buffer_read_ctrl_pkg::*;
#(
    parameter int DEPTH = RAM_LAT_DEF + 1
) (
    input  logic clock,
    input  logic clear,
    input  logic vld_i,
    input  logic last_i,
    output logic vld_o,
    output logic last_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;

    // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
    always_ff @(posedge clock) begin
        if (clear) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], vld_i};
            last_q <= {last_q[DEPTH-2:0], last_i};
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];

endmodule

// File: rtl/fm_buffer_read_ctrl.sv
// Sweeps every word of every feature-map buffer once buffer_full is raised and
// streams the pixels out. Define FM_RD_PAUSE_EN to add the pause input.
module fm_buffer_read_ctrl
    import fm_buffer_read_ctrl_pkg::*;
#(
    parameter int NUM_KERNELS  = NUM_KERNELS_DEF,
    parameter int FM_DEPTH     = FM_DEPTH_DEF,
    parameter int RAM_LAT      = RAM_LAT_DEF,
    localparam int RD_ADDR_W   = clog2_w(FM_DEPTH),
    localparam int RD_SEL_W    = clog2_w(NUM_KERNELS),
    localparam int RD_WADDR_W  = clog2_w(NUM_KERNELS * FM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  buffer_full,
`ifdef FM_RD_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [RD_ADDR_W-1:0]  rdaddress,
    output logic [RD_SEL_W-1:0]   ram_select,
    input  logic [PIXEL_W-1:0]    data_out,
    output logic [RD_WADDR_W-1:0] weight_addr,
    output logic [PIXEL_W-1:0]    feature_pixel,
    output logic                  dval,
    output logic                  last,
    output logic                  buffer_release,
    output logic                  busy
);

    localparam int DRAIN_W = clog2_w(RAM_LAT + 1);
    localparam logic [RD_ADDR_W-1:0] ADDR_MAX  = RD_ADDR_W'(FM_DEPTH - 1);
    localparam logic [RD_SEL_W-1:0]  KSEL_MAX  = RD_SEL_W'(NUM_KERNELS - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_MAX = DRAIN_W'(RAM_LAT);

    rd_state_e               state_q;
    logic [RD_ADDR_W-1:0]    addr_q;
    logic [RD_SEL_W-1:0]     ksel_q;
    logic [RD_WADDR_W-1:0]   waddr_q;
    logic [DRAIN_W-1:0]      drain_q;
    logic                    release_q;
    logic                    busy_q;
    logic [PIXEL_W-1:0]      pixel_q;
    logic                    issue;
    logic                    issue_last;

    // A read is issued in every READ cycle that is not paused.
`ifdef FM_RD_PAUSE_EN
    assign issue = (state_q == ST_READ) && !pause;
`else
    assign issue = (state_q == ST_READ);
`endif
    assign issue_last = issue && (addr_q == ADDR_MAX) && (ksel_q == KSEL_MAX);

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ksel_q    <= '0;
            waddr_q   <= '0;
            drain_q   <= '0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            release_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (buffer_full) begin
                        state_q <= ST_READ;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        ksel_q  <= '0;
                        waddr_q <= '0;
                    end
                end
                ST_READ: begin
                    if (issue_last) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end else if (issue) begin
                        waddr_q <= waddr_q + 1'b1;
                        if (addr_q == ADDR_MAX) begin
                            addr_q <= '0;
                            ksel_q <= ksel_q + 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last issued word leaves the pixel register RAM_LAT+1 cycles later.
                    if (drain_q == DRAIN_MAX) begin
                        state_q   <= ST_RELEASE;
                        release_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!buffer_full) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= data_out;
        end
    end

    fm_rd_valid_pipe #(
        .DEPTH (RAM_LAT + 1)
    ) u_valid_pipe (
        .clock  (clock),
        .clear  (reset),
        .vld_i  (issue),
        .last_i (issue_last),
        .vld_o  (dval),
        .last_o (last)
    );

    assign rdaddress      = addr_q;
    assign ram_select     = ksel_q;
    assign weight_addr    = waddr_q;
    assign feature_pixel  = pixel_q;
    assign buffer_release = release_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fm_buffer_read_ctrl.sv
// Randomized bench for fm_buffer_read_ctrl (2 kernels x 4 words, RAM_LAT 2)
// against a schedule-based reference model; covers FM_RD_PAUSE_EN when defined.
module tb_fm_buffer_read_ctrl;
    import fm_buffer_read_ctrl_pkg::*;

    localparam int NK = 2;
    localparam int FD = 4;
    localparam int RL = 2;
    localparam int N  = NK * FD;
`ifdef FM_RD_PAUSE_EN
    localparam int PAUSE_SCALE = 1;
`else
    localparam int PAUSE_SCALE = 0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               buffer_full;
`ifdef FM_RD_PAUSE_EN
    logic               pause;
`endif
    logic [1:0]         rdaddress;
    logic [0:0]         ram_select;
    logic [2:0]         weight_addr;
    logic [PIXEL_W-1:0] data_out;
    logic [PIXEL_W-1:0] ram_d1;
    logic [PIXEL_W-1:0] feature_pixel;
    logic               dval;
    logic               last;
    logic               buffer_release;
    logic               busy;

    logic [PIXEL_W-1:0] mem [NK][FD];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fm_buffer_read_ctrl #(
        .NUM_KERNELS (NK),
        .FM_DEPTH    (FD),
        .RAM_LAT     (RL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .buffer_full    (buffer_full),
`ifdef FM_RD_PAUSE_EN
        .pause          (pause),
`endif
        .rdaddress      (rdaddress),
        .ram_select     (ram_select),
        .data_out       (data_out),
        .weight_addr    (weight_addr),
        .feature_pixel  (feature_pixel),
        .dval           (dval),
        .last           (last),
        .buffer_release (buffer_release),
        .busy           (busy)
    );

    // Buffer RAM plus read mux: data appears RL cycles after the address.
    always @(posedge clock) begin
        ram_d1   <= mem[ram_select][rdaddress];
        data_out <= ram_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sweep from IDLE. drop_at: cycle buffer_full falls (0 = held high).
    // Pause covers cycles [p_start, p_start+p_len) in the pause build.
    task automatic run_sweep(input string name, input int drop_at,
                             input int p_start, input int p_len, input int tail);
        int issue_cyc[N];
        int t_next;
        int eff_len;
        int last_issue;
        int idx;
        int found;
        int rel_seen;
        int rel_cyc;
        eff_len = p_len * PAUSE_SCALE;
        t_next  = 1;
        for (int i = 0; i < N; i++) begin
            while (t_next >= p_start && t_next < p_start + eff_len) t_next++;
            issue_cyc[i] = t_next;
            t_next++;
        end
        last_issue = issue_cyc[N-1];
        rel_seen   = 0;
        rel_cyc    = 0;

        @(posedge clock); #1;
        buffer_full = 1'b1;
        for (int t = 1; t <= last_issue + tail; t++) begin
            @(posedge clock); #1;
`ifdef FM_RD_PAUSE_EN
            pause = (t >= p_start) && (t < p_start + p_len);
`endif
            if (t == drop_at) buffer_full = 1'b0;
            @(negedge clock);
            if (t <= last_issue) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (issue_cyc[i] < t) idx++;
                check({name, "/rdaddress"}, rdaddress, idx % FD);
                check({name, "/ram_select"}, ram_select, idx / FD);
                check({name, "/weight_addr"}, weight_addr, idx);
            end
            found = -1;
            for (int i = 0; i < N; i++) if (issue_cyc[i] == t - RL - 1) found = i;
            check({name, "/dval"}, dval, found >= 0);
            if (found >= 0) begin
                check({name, "/pixel"}, feature_pixel, mem[found / FD][found % FD]);
                check({name, "/last"}, last, found == N - 1);
            end else begin
                check({name, "/last_idle"}, last, 0);
            end
            if (buffer_release) begin
                rel_seen++;
                rel_cyc = t;
            end
        end
`ifdef FM_RD_PAUSE_EN
        pause = 1'b0;
`endif
        check({name, "/release_count"}, rel_seen, 1);
        check({name, "/release_after_last"}, rel_cyc > last_issue + RL + 1, 1);
        if (drop_at == 0) check({name, "/busy_held"}, busy, 1);
        buffer_full = 1'b0;
        repeat (3) @(negedge clock);
        check({name, "/idle_after"}, busy, 0);
    endtask

    task automatic reset_mid_sweep();
        int seen;
        int t;
        int rel_cnt;
        int dv_cnt;
        seen = 0;
        t    = 0;
        @(posedge clock); #1;
        buffer_full = 1'b1;
        while (seen < 3 && t < 40) begin
            @(negedge clock);
            t++;
            if (dval) seen++;
        end
        check("rst/third_dval", seen, 3);
        reset       = 1'b1;
        buffer_full = 1'b0;
        @(negedge clock);
        check("rst/dval", dval, 0);
        check("rst/last", last, 0);
        check("rst/busy", busy, 0);
        check("rst/release", buffer_release, 0);
        reset   = 1'b0;
        rel_cnt = 0;
        dv_cnt  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (buffer_release) rel_cnt++;
            if (dval) dv_cnt++;
        end
        check("rst/no_release", rel_cnt, 0);
        check("rst/no_dval", dv_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        buffer_full = 1'b0;
`ifdef FM_RD_PAUSE_EN
        pause       = 1'b0;
`endif
        for (int k = 0; k < NK; k++)
            for (int a = 0; a < FD; a++)
                mem[k][a] = PIXEL_W'(16 * k + a);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset/dval", dval, 0);
        check("reset/last", last, 0);
        check("reset/release", buffer_release, 0);
        check("reset/busy", busy, 0);
        check("reset/pixel", feature_pixel, 0);
        check("reset/rdaddress", rdaddress, 0);
        check("reset/ram_select", ram_select, 0);
        check("reset/weight_addr", weight_addr, 0);
        reset = 1'b0;
        repeat (5) @(posedge clock);

        run_sweep("base", 0, 0, 0, 12);
        run_sweep("hold", 0, 0, 0, 24);
        run_sweep("drop", 4, 0, 0, 12);
        run_sweep("pause", 0, 3, 3, 12);
        reset_mid_sweep();
        run_sweep("post_rst", 0, 0, 0, 12);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NK; k++)
                for (int a = 0; a < FD; a++)
                    mem[k][a] = PIXEL_W'($urandom);
            run_sweep($sformatf("rand%0d", r), $urandom_range(0, N),
                      $urandom_range(2, N), $urandom_range(0, 4), 12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_buffer_read_ctrl.md
Name: fm_buffer_read_ctrl

Overview:
Read-side controller for the per-kernel feature-map RAM buffers. The write-side buffer controller fills these buffers and raises buffer_full. This block then sweeps every address of every kernel buffer through the read port mux. It delivers a valid-qualified pixel stream, with matching weight addresses, to the np_matrix_mult instances, and releases the buffers back to the writer when the sweep is complete.

Parameters:
NUM_KERNELS, 8, number of feature-map buffers (one per kernel)
FM_DEPTH, 1024, words per feature-map buffer
FM_ADDR_W, 10, rdaddress width (clog2(FM_DEPTH))
KSEL_W, 3, ram_select width (clog2(NUM_KERNELS))
WADDR_W, 13, weight address width (clog2(NUM_KERNELS*FM_DEPTH))
PIXEL_W, 8, feature pixel width
RAM_LAT, 2, cycles from rdaddress/ram_select to data_out valid (RAM plus mux)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
buffer_full  in  1  level; all feature-map buffers written
rdaddress  out  FM_ADDR_W  shared read address to all fm_buffer instances
ram_select  out  KSEL_W  read_port_mux select
data_out  in  PIXEL_W  read_port_mux output
weight_addr  out  WADDR_W  weight buffer address, issued in the same cycle as rdaddress
feature_pixel  out  PIXEL_W  registered pixel to matrix multipliers
dval  out  1  feature_pixel valid
last  out  1  marks final pixel of the sweep; coincident with dval
buffer_release  out  1  one-cycle pulse; writer may overwrite buffers
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-high.
- Reset values: all outputs 0. FSM enters IDLE. Valid/last delay pipeline is cleared.
- FSM states:
  - IDLE: on buffer_full=1, go to READ. Address counter and kernel counter are 0.
  - READ: issues one read per cycle. Order is kernel-major: ram_select=k, rdaddress=a, with a incrementing 0..FM_DEPTH-1, then k incrementing. weight_addr = k*FM_DEPTH + a, kept as a single linear counter. After issuing k=NUM_KERNELS-1, a=FM_DEPTH-1, go to DRAIN.
  - DRAIN: no new reads issued. Stays until the issue pipeline is empty, i.e. RAM_LAT+1 cycles after the last issue. Then goes to RELEASE.
  - RELEASE: buffer_release=1 for exactly one cycle on entry. Stays until buffer_full=0, then goes to IDLE.
- Timing:
  - A read issued at cycle T returns data_out at T+RAM_LAT.
  - feature_pixel is registered from data_out; dval=1 at T+RAM_LAT+1.
  - Total dval pulses per sweep = NUM_KERNELS*FM_DEPTH, contiguous, with no bubbles.
- Address outputs: rdaddress, ram_select and weight_addr hold their last issued value outside READ. They are don't-care when no read is in flight; implement as hold.
- last is asserted with the dval of the final word only.
- Boundaries:
  - buffer_full dropping during READ or DRAIN is ignored; the sweep completes.
  - buffer_full still high when entering RELEASE: no re-trigger until it has been seen low.
  - Counter wrap occurs only at sweep end; counters reset to 0 on entry to READ.
- Reset mid-sweep: immediate return to IDLE. Pending dval and last are killed in the same cycle. No buffer_release pulse is issued.

Optional Feature:
FM_RD_PAUSE_EN
- With the macro defined: adds input port pause (1 bit). While pause=1 in READ, no new read is issued and the counters hold. Reads already in flight still complete and emit dval. pause has no effect in other states.
- Without the macro: no pause port; READ issues one read every cycle unconditionally.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, READ, DRAIN, RELEASE.
  - Width constants FM_ADDR_W, KSEL_W, WADDR_W, PIXEL_W, all derived from NUM_KERNELS and FM_DEPTH.
  - Default RAM_LAT.
- One natural sub-module: fm_rd_valid_pipe, a RAM_LAT+1 stage shift register carrying the valid and last flags, with synchronous clear.

Test Plan:
- Params NUM_KERNELS=2, FM_DEPTH=4, RAM_LAT=2. Assert buffer_full at cycle 10.
  - Expect rdaddress 0,1,2,3,0,1,2,3 with ram_select 0,0,0,0,1,1,1,1 and weight_addr 0..7 over cycles 11..18.
  - Expect 8 contiguous dval pulses from cycle 14, with last at cycle 21.
- Preload buffer k word a with 16*k+a; run a sweep -> feature_pixel sequence is 0,1,2,3,16,17,18,19.
- Hold buffer_full high after the sweep -> exactly one buffer_release pulse and no second sweep. Drop and re-raise buffer_full -> a second identical sweep starts.
- Drop buffer_full mid-READ -> the sweep still produces all 8 dval pulses and then buffer_release.
- Assert reset on the 3rd dval cycle -> dval, last, busy and buffer_release are 0 on the next cycle and no release pulse follows. A fresh buffer_full produces a full sweep.
- With FM_RD_PAUSE_EN, pause=1 for 3 cycles after the 2nd issue:
  - rdaddress holds at 2.
  - dval shows a 3-cycle gap.
  - Still exactly 8 words in order.
